// File: rtl/seg7_bcd_updown_scan_pkg.sv
// Shared display definitions: abcdefg segment patterns, BCD helpers and the
// BCD-to-7-segment decoder used by this and other display blocks.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  // Count direction as carried by the up_dn pin.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Segment order is a..g from MSB to LSB, active high.
  localparam logic [6:0] SEG7_0     = 7'b1111110;
  localparam logic [6:0] SEG7_1     = 7'b0110000;
  localparam logic [6:0] SEG7_2     = 7'b1101101;
  localparam logic [6:0] SEG7_3     = 7'b1111001;
  localparam logic [6:0] SEG7_4     = 7'b0110011;
  localparam logic [6:0] SEG7_5     = 7'b1011011;
  localparam logic [6:0] SEG7_6     = 7'b1011111;
  localparam logic [6:0] SEG7_7     = 7'b1110000;
  localparam logic [6:0] SEG7_8     = 7'b1111111;
  localparam logic [6:0] SEG7_9     = 7'b1111011;
  localparam logic [6:0] SEG7_BLANK = 7'b0000000;

  // Select code of the rightmost of the six physical digits.
  localparam logic [2:0] SEL_RIGHTMOST = 3'd5;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Non-decimal codes decode to an unlit digit rather than garbage.
  function automatic logic [6:0] bcd_to_seg7(input bcd_t bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG7_0;
      4'd1:    seg = SEG7_1;
      4'd2:    seg = SEG7_2;
      4'd3:    seg = SEG7_3;
      4'd4:    seg = SEG7_4;
      4'd5:    seg = SEG7_5;
      4'd6:    seg = SEG7_6;
      4'd7:    seg = SEG7_7;
      4'd8:    seg = SEG7_8;
      4'd9:    seg = SEG7_9;
      default: seg = SEG7_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_bcd_updown_scan_if.sv
// Control/status bundle between board switches, the counter and the display pins.
interface seg7_bcd_updown_scan_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    enable;
  logic                    up_dn;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    carry;
  logic [2:0]              seg7_sel;
  logic [6:0]              seg7_out;
  logic                    dpt_out;
  logic                    led_com;

  // Board side: drives the controls, watches the count and display pins.
  modport master (
    output enable, up_dn, load, load_value,
    input  count_bcd, carry, seg7_sel, seg7_out, dpt_out, led_com
  );

  // Counter side.
  modport slave (
    input  enable, up_dn, load, load_value,
    output count_bcd, carry, seg7_sel, seg7_out, dpt_out, led_com
  );
endinterface

// File: rtl/seg7_bcd_updown_scan_digit.sv
// One BCD digit: parallel load (clamped to 9), up/down step with 9<->0 roll,
// and terminal-value flags used to ripple enables to the next digit.
module bcd_digit_updn
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_up_dn,
  input  logic i_load,
  input  bcd_t i_load_val,
  output bcd_t o_digit,
  output logic o_is_max,
  output logic o_is_min
);

  bcd_t r_digit;
  bcd_t w_load_clamped;
  dir_e w_dir;

  assign w_dir          = dir_e'(i_up_dn);
  assign w_load_clamped = (i_load_val > BCD_MAX) ? BCD_MAX : i_load_val;

  // Digit register: load wins over stepping; stepping wraps at the BCD ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= BCD_MIN;
    end else if (i_load) begin
      r_digit <= w_load_clamped;
    end else if (i_en) begin
      if (w_dir == DIR_UP) begin
        r_digit <= o_is_max ? BCD_MIN : r_digit + 4'd1;
      end else begin
        r_digit <= o_is_min ? BCD_MAX : r_digit - 4'd1;
      end
    end
  end

  assign o_digit  = r_digit;
  assign o_is_max = (r_digit == BCD_MAX);
  assign o_is_min = (r_digit == BCD_MIN);

endmodule

// File: rtl/seg7_bcd_updown_scan.sv
// N-digit BCD up/down counter with parallel load, wrap/borrow pulse and a
// multiplexed 7-segment scan with optional leading-zero blanking.
// Prescalers produce single-cycle enables; everything runs on clk.
module seg7_bcd_updown_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int COUNT_DIV_EXP = 22,
  parameter int SCAN_DIV_EXP  = 15,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_bcd_updown_scan_if.slave bus
);

  // Scan wraps back to the rightmost digit after showing the leftmost used one.
  localparam logic [2:0] SEL_LAST = 3'(6 - NUM_DIGITS);

  logic [COUNT_DIV_EXP-1:0] r_count_div;
  logic [SCAN_DIV_EXP-1:0]  r_scan_div;
  logic                     r_carry;
  logic [2:0]               r_sel;

  logic                  w_count_tick;
  logic                  w_scan_tick;
  logic                  w_count_en;
  logic                  w_wrap;
  logic [NUM_DIGITS-1:0] w_is_max;
  logic [NUM_DIGITS-1:0] w_is_min;
  logic [NUM_DIGITS-1:0] w_digit_en;
  logic [NUM_DIGITS:0]   w_lower_max;
  logic [NUM_DIGITS:0]   w_lower_min;
  logic [NUM_DIGITS:0]   w_upper_zero;
  bcd_t                  w_digit [NUM_DIGITS];
  bcd_t                  w_cur_digit;
  logic                  w_cur_blank;

  assign w_count_tick = &r_count_div;
  assign w_scan_tick  = &r_scan_div;

  // Load takes the cycle outright, so a coincident tick is dropped, not deferred.
  assign w_count_en = w_count_tick & bus.enable & ~bus.load;

  // Free-running prescalers; load never disturbs them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count_div <= '0;
      r_scan_div  <= '0;
    end else begin
      r_count_div <= r_count_div + COUNT_DIV_EXP'(1);
      r_scan_div  <= r_scan_div + SCAN_DIV_EXP'(1);
    end
  end

  // Ripple chains: "all lower digits at 9/0" for carry/borrow, and
  // "this and all higher digits are 0" for blanking.
  always_comb begin
    logic run_max;
    logic run_min;
    logic run_zero;
    run_max  = 1'b1;
    run_min  = 1'b1;
    run_zero = 1'b1;
    w_lower_max  = '0;
    w_lower_min  = '0;
    w_upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_lower_max[i] = run_max;
      w_lower_min[i] = run_min;
      run_max        = run_max & w_is_max[i];
      run_min        = run_min & w_is_min[i];
    end
    w_lower_max[NUM_DIGITS]  = run_max;
    w_lower_min[NUM_DIGITS]  = run_min;
    w_upper_zero[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero        = run_zero & w_is_min[i];
      w_upper_zero[i] = run_zero;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_digit_en[gi] = w_count_en & (bus.up_dn ? w_lower_max[gi] : w_lower_min[gi]);

      bcd_digit_updn u_digit (
        .clk        (clk),
        .rst_n      (reset),
        .i_en       (w_digit_en[gi]),
        .i_up_dn    (bus.up_dn),
        .i_load     (bus.load),
        .i_load_val (bus.load_value[4*gi +: 4]),
        .o_digit    (w_digit[gi]),
        .o_is_max   (w_is_max[gi]),
        .o_is_min   (w_is_min[gi])
      );

      assign bus.count_bcd[4*gi +: 4] = w_digit[gi];
    end
  endgenerate

  // Whole counter wraps when every digit sits at the terminal value for the direction.
  assign w_wrap = bus.up_dn ? w_lower_max[NUM_DIGITS] : w_lower_min[NUM_DIGITS];

  // Registered wrap/borrow pulse, one clk wide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_count_en & w_wrap;
    end
  end

  // Scan pointer walks right to left across the used digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel <= SEL_RIGHTMOST;
    end else if (w_scan_tick) begin
      r_sel <= (r_sel == SEL_LAST) ? SEL_RIGHTMOST : r_sel - 3'd1;
    end
  end

  // Pick the digit under the scan pointer and decide whether it is a leading zero.
  always_comb begin
    w_cur_digit = BCD_MIN;
    w_cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel == SEL_RIGHTMOST - 3'(i)) begin
        w_cur_digit = w_digit[i];
        w_cur_blank = BLANK_LEADING && (i != 0) && w_upper_zero[i];
      end
    end
  end

  assign bus.carry    = r_carry;
  assign bus.seg7_sel = r_sel;
  assign bus.seg7_out = w_cur_blank ? SEG7_BLANK : bcd_to_seg7(w_cur_digit);
  assign bus.dpt_out  = 1'b0;
  assign bus.led_com  = 1'b1;

endmodule
